alu_issue: RTL
==============

// Module: alu_issue
// PURPOSE
//  Upstream issue stage for the ALU. Accepts opcode and operand commands on a valid/ready handshake.
//  Buffers them in a small FIFO. Presents one command per cycle on registered outputs that drive the
//  ALU's Opc_i/DinA_i/DinB_i. Flags the cycle in which the ALU's registered Dout_o/OverFlow_o belong to
//  an issued command (ALU latency = 1 clk). A downstream Stall_i holds issue off.
// PARAMETERS
//  WIDTH  32  operand/result width; must equal the ALU datapath width
//  DEPTH  4   command FIFO entries; power of 2, >= 2
// PORTS
//  Clk_i       in   1                  clock, all state on rising edge
//  Reset_i     in   1                  asynchronous reset, active-high
//  Valid_i     in   1                  upstream command valid
//  Ready_o     out  1                  FIFO can accept command (= !full && !Reset_i)
//  Opc_i       in   2                  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR
//  DinA_i      in   WIDTH              operand A
//  DinB_i      in   WIDTH              operand B
//  Stall_i     in   1                  downstream stall; 1 = no issue this cycle
//  Opc_o       out  2                  registered opcode to ALU
//  DinA_o      out  WIDTH              registered operand A to ALU
//  DinB_o      out  WIDTH              registered operand B to ALU
//  Issue_o     out  1                  1 = Opc_o/DinA_o/DinB_o carry a newly issued command
//  ResValid_o  out  1                  1 = ALU Dout_o/OverFlow_o this cycle is the result of an issue
//  Level_o     out  $clog2(DEPTH)+1    FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (async assert, sync-safe release):
//   - Opc_o, DinA_o, DinB_o, Issue_o, ResValid_o, Level_o = 0; FIFO pointers = 0; Ready_o = 0 while Reset_i=1.
//  Push: Valid_i && Ready_o at rising edge -> {Opc_i,DinA_i,DinB_i} written at wr_ptr; wr_ptr++ mod DEPTH.
//  Pop: !empty && !Stall_i at rising edge.
//   - Head entry loaded into Opc_o/DinA_o/DinB_o; Issue_o <= 1; rd_ptr++ mod DEPTH.
//  No pop: Issue_o <= 0; Opc_o/DinA_o/DinB_o hold last value (never return to 0 except on reset).
//  ResValid_o <= Issue_o each edge, i.e. high exactly one cycle after each Issue_o cycle.
//  Latency: push at edge N -> Issue_o high after edge N+1 -> ResValid_o high after edge N+2.
//   - No same-cycle empty bypass.
//  Full: Ready_o = 0; a simultaneous pop does NOT enable a push that cycle (Ready_o depends on full only).
//  Empty: no pop regardless of Stall_i; Issue_o = 0.
//  Simultaneous push and pop (not full, not empty): Level_o unchanged, both pointers advance.
//  Pointer wrap: pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
//   - full/empty derived from Level_o (DEPTH / 0).
//  Stall_i only blocks pop; pushes continue until full. Stall_i has no effect on ResValid_o of an issued cmd.
//  Reset mid-operation: all buffered and in-flight commands discarded.
//   - Issue_o/ResValid_o drop to 0 immediately on Reset_i assertion.
//  Level_o changes: +1 on push-only, -1 on pop-only, else hold; never exceeds DEPTH or underflows.
// STRUCTURE
//  Package alu_pkg:
//   - typedef enum logic [1:0] opc_t {OPC_ADD=0, OPC_SUB=1, OPC_AND=2, OPC_OR=3}.
//   - typedef struct packed {opc_t opc; logic [WIDTH-1:0] a, b;} alu_cmd_t (WIDTH default 32 as pkg localparam).
//  Sub-module sync_fifo (DEPTH, payload width param; push/pop/full/empty/level) holds the command storage.
//  alu_issue adds the issue register and ResValid_o delay stage.
// TESTING
//  1 Reset_i=1 with Valid_i=1 -> Ready_o=0, all outputs 0, Level_o=0; release -> Ready_o=1 next cycle.
//  2 Push ADD A=5 B=7, Stall_i=0 -> Issue_o one cycle later with Opc_o=0, DinA_o=5, DinB_o=7.
//    ResValid_o next cycle; ALU Dout_o=12.
//  3 Stall_i=1, push 5 cmds with DEPTH=4 -> Level_o=4, Ready_o=0, 5th not accepted.
//    Release stall -> 4 Issue_o pulses back-to-back in push order.
//  4 Continuous push+pop for 10 cmds (SUB A=i+1, B=i) -> Level_o steady at 1.
//    Pointers wrap twice; every ResValid_o cycle Dout_o=1.
//  5 Push ADD A=32'hFFFF_FFFF B=1 -> issued unchanged, ResValid_o=1 with ALU Dout_o=0, OverFlow_o=1.
//  6 Assert Reset_i while Level_o=3 and Issue_o=1 -> Issue_o/ResValid_o/Level_o=0 same cycle.
//    No stale issue after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcode encoding and the command record.
package alu_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      OPC_ADD = 2'd0,
      OPC_SUB = 2'd1,
      OPC_AND = 2'd2,
      OPC_OR  = 2'd3
   } opc_t;

   typedef struct packed {
      opc_t             opc;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } alu_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty are derived from the count so
// the pointers can wrap freely.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic                     Clk_i,
   input  logic                     Reset_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [DW-1:0]            wdata_i,
   output logic [DW-1:0]            rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          push_ok, pop_ok;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // NOTE: always_comb assigns every output a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge Clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of a 1-cycle ALU: buffers commands, issues one per cycle on
// registered outputs and flags the cycle in which the ALU result belongs to an issue.
module alu_issue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     Clk_i,
   input  logic                     Reset_i,
   input  logic                     Valid_i,
   output logic                     Ready_o,
   input  logic [1:0]               Opc_i,
   input  logic [WIDTH-1:0]         DinA_i,
   input  logic [WIDTH-1:0]         DinB_i,
   input  logic                     Stall_i,
   output logic [1:0]               Opc_o,
   output logic [WIDTH-1:0]         DinA_o,
   output logic [WIDTH-1:0]         DinB_o,
   output logic                     Issue_o,
   output logic                     ResValid_o,
   output logic [$clog2(DEPTH):0]   Level_o
);

   import alu_pkg::*;

   localparam int CW = 2 + 2 * WIDTH;

   logic [CW-1:0]    wr_cmd, head_cmd;
   logic             full, empty, push, pop;
   opc_t             opc_q, opc_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             issue_q, issue_d;
   logic             res_valid_q, res_valid_d;

   // Ready looks only at full, so a pop in the same cycle never frees a slot early.
   assign Ready_o = !full && !Reset_i;
   assign push    = Valid_i && Ready_o;
   assign pop     = !empty && !Stall_i;
   assign wr_cmd  = {Opc_i, DinA_i, DinB_i};

   sync_fifo #(
      .DEPTH (DEPTH),
      .DW    (CW)
   ) u_fifo (
      .Clk_i   (Clk_i),
      .Reset_i (Reset_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_cmd),
      .rdata_o (head_cmd),
      .full_o  (full),
      .empty_o (empty),
      .level_o (Level_o)
   );

   always_comb begin
      opc_d       = opc_q;
      a_d         = a_q;
      b_d         = b_q;
      issue_d     = pop;
      res_valid_d = issue_q;
      if (pop) begin
         opc_d = opc_t'(head_cmd[CW-1 -: 2]);
         a_d   = head_cmd[2*WIDTH-1 -: WIDTH];
         b_d   = head_cmd[WIDTH-1:0];
      end
   end

   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         opc_q       <= OPC_ADD;
         a_q         <= '0;
         b_q         <= '0;
         issue_q     <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         opc_q       <= opc_d;
         a_q         <= a_d;
         b_q         <= b_d;
         issue_q     <= issue_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign Opc_o      = opc_q;
   assign DinA_o     = a_q;
   assign DinB_o     = b_q;
   assign Issue_o    = issue_q;
   assign ResValid_o = res_valid_q;

endmodule
